// File: rtl/piece_mover.sv
// piece_mover: owns the falling piece on the 8x4 board. Samples the freshly
// cleared/spawned board, applies gravity, lateral moves and hard drop, and
// merges the piece into the static board when it can no longer descend.
module piece_mover #(
    parameter int unsigned GRAVITY_TICKS = 8
) (
    input  logic        clka,
    input  logic        restart,
    input  logic [31:0] board_in,
    input  logic        error_in,
    input  logic [1:0]  curr_piece,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_drop,
    output logic [2:0]  state,
    output logic [31:0] board_out,
    output logic        locked,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StGen   = 3'd0,
        StSpawn = 3'd1,
        StFall  = 3'd2,
        StDrop  = 3'd3,
        StLock  = 3'd4,
        StOver  = 3'd5
    } state_e;

    // Column 0 / column 3 bits of every row.
    localparam logic [31:0] Col0Mask = 32'h1111_1111;
    localparam logic [31:0] Col3Mask = 32'h8888_8888;
    localparam logic [7:0]  LastTick = 8'(GRAVITY_TICKS - 1);

    state_e      state_q, state_d;
    logic [31:0] active_q, active_d;
    logic [31:0] static_q, static_d;
    logic [31:0] board_q, board_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        game_over_q, game_over_d;

    logic [31:0] spawn_mask;
    logic [31:0] left_mask, right_mask, down_mask;
    logic        left_ok, right_ok, down_ok;

    // Spawn shape and candidate moves with their legality.
    always_comb begin
        spawn_mask = 32'h0;
        unique case (curr_piece)
            2'b00: spawn_mask = 32'h0000_0002;
            2'b01: spawn_mask = 32'h0000_0006;
            2'b10: spawn_mask = 32'h0000_0066;
            2'b11: spawn_mask = 32'h0000_0062;
            default: spawn_mask = 32'h0;
        endcase
        left_mask  = active_q >> 1;
        right_mask = active_q << 1;
        down_mask  = active_q << 4;
        left_ok    = ~(|(active_q & Col0Mask)) && ~(|(left_mask & static_q));
        right_ok   = ~(|(active_q & Col3Mask)) && ~(|(right_mask & static_q));
        down_ok    = ~(|active_q[31:28]) && ~(|(down_mask & static_q));
    end

    // Next-state: FSM transitions, piece movement, merge and board snapshot.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        static_d    = static_q;
        cnt_d       = cnt_q;
        game_over_d = game_over_q;
        board_d     = static_q | active_q;
        case (state_q)
            StGen: state_d = StSpawn;
            StSpawn: begin
                if (error_in) begin
                    state_d     = StOver;
                    game_over_d = 1'b1;
                end else begin
                    active_d = spawn_mask;
                    static_d = board_in & ~spawn_mask;
                    cnt_d    = 8'd0;
                    state_d  = StFall;
                end
            end
            StFall: begin
                if (btn_drop) begin
                    state_d = StDrop;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LastTick) begin
                    // Gravity step wins over lateral buttons this cycle.
                    cnt_d = 8'd0;
                    if (down_ok) begin
                        active_d = down_mask;
                    end else begin
                        state_d = StLock;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (btn_left && !btn_right && left_ok) begin
                        active_d = left_mask;
                    end else if (btn_right && !btn_left && right_ok) begin
                        active_d = right_mask;
                    end
                end
            end
            StDrop: begin
                if (down_ok) begin
                    active_d = down_mask;
                end else begin
                    state_d = StLock;
                end
            end
            StLock: begin
                static_d = static_q | active_q;
                active_d = 32'h0;
                state_d  = StGen;
            end
            StOver: begin
                board_d     = board_q;
                game_over_d = 1'b1;
            end
            default: state_d = StGen;
        endcase
    end

    // State registers with synchronous restart.
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q     <= StGen;
            active_q    <= 32'h0;
            static_q    <= 32'h0;
            board_q     <= 32'h0;
            cnt_q       <= 8'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            static_q    <= static_d;
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            game_over_q <= game_over_d;
        end
    end

    // Output mapping.
    always_comb begin
        state     = state_q;
        board_out = board_q;
        locked    = (state_q == StLock);
        game_over = game_over_q;
    end

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover: expectations are queued as stimulus is driven
// and popped/compared one clock later, 1 time unit after the rising edge.
module tb_piece_mover;

    logic        clka = 1'b0;
    logic        restart = 1'b1;
    logic [31:0] board_in = 32'h0;
    logic        error_in = 1'b0;
    logic [1:0]  curr_piece = 2'b00;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_drop = 1'b0;
    logic [2:0]  state;
    logic [31:0] board_out;
    logic        locked;
    logic        game_over;

    piece_mover #(.GRAVITY_TICKS(4)) dut (
        .clka      (clka),
        .restart   (restart),
        .board_in  (board_in),
        .error_in  (error_in),
        .curr_piece(curr_piece),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .state     (state),
        .board_out (board_out),
        .locked    (locked),
        .game_over (game_over)
    );

    always #5 clka = ~clka;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    function automatic logic [31:0] observe(int unsigned sel);
        case (sel)
            0: return {29'h0, state};
            1: return board_out;
            2: return {31'h0, locked};
            default: return {31'h0, game_over};
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic exp_st(input string tag, input logic [31:0] v); push(tag, 0, v); endtask
    task automatic exp_bd(input string tag, input logic [31:0] v); push(tag, 1, v); endtask
    task automatic exp_lk(input string tag, input logic [31:0] v); push(tag, 2, v); endtask
    task automatic exp_go(input string tag, input logic [31:0] v); push(tag, 3, v); endtask

    // Advance one clock, then drain the scoreboard against the DUT outputs.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clka);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        restart = 1'b1;
        exp_st({tag, "_rst_state"}, 0);
        exp_bd({tag, "_rst_board"}, 0);
        exp_lk({tag, "_rst_locked"}, 0);
        exp_go({tag, "_rst_go"}, 0);
        tick();
        restart = 1'b0;
    endtask

    initial begin
        // Test 1: square falls one row after four FALL cycles.
        board_in   = 32'h0000_0066;
        curr_piece = 2'b10;
        do_reset("t1");
        exp_st("t1_spawn", 1);
        tick();
        exp_st("t1_fall", 2);
        exp_bd("t1_board_e2", 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_bd("t1_board_top", 32'h0000_0066);
            tick();
        end
        exp_bd("t1_board_row1", 32'h0000_0660);
        exp_st("t1_still_fall", 2);
        tick();

        // Test 2: lateral moves, column blocks, both-button no-op.
        board_in   = 32'h0000_0002;
        curr_piece = 2'b00;
        do_reset("t2");
        tick();
        exp_st("t2_fall", 2);
        tick();
        btn_left = 1'b1;
        exp_bd("t2_pre_left", 32'h2);
        tick();
        exp_bd("t2_left1", 32'h1);
        tick();
        exp_bd("t2_left_blk", 32'h1);
        tick();
        btn_left = 1'b0;
        exp_bd("t2_left_hold", 32'h1);
        tick();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        exp_bd("t2_gravity", 32'h10);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_bd("t2_both", 32'h10);
            tick();
        end
        btn_left = 1'b0;
        exp_bd("t2_right0", 32'h100);
        tick();
        exp_bd("t2_right1", 32'h200);
        tick();
        exp_bd("t2_right2", 32'h400);
        tick();
        exp_bd("t2_right3", 32'h800);
        tick();
        exp_bd("t2_grav_over_right", 32'h8000);
        tick();
        btn_right = 1'b0;
        exp_bd("t2_right_blk", 32'h8000);
        tick();

        // Test 3: hard drop of a square to the floor, buttons ignored in DROP.
        board_in   = 32'h0000_0066;
        curr_piece = 2'b10;
        do_reset("t3");
        tick();
        tick();
        btn_drop = 1'b1;
        exp_st("t3_drop", 3);
        tick();
        btn_drop = 1'b0;
        btn_left = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_st("t3_drop_st", 3);
            exp_lk("t3_drop_lk", 0);
            exp_bd("t3_drop_bd", 32'h0000_0066 << (4 * i));
            tick();
        end
        exp_st("t3_lock", 4);
        exp_lk("t3_lock_pulse", 1);
        exp_bd("t3_lock_bd", 32'h6600_0000);
        tick();
        btn_left = 1'b0;
        exp_st("t3_gen", 0);
        exp_lk("t3_lock_gone", 0);
        exp_bd("t3_merged", 32'h6600_0000);
        tick();
        exp_st("t3_respawn", 1);
        exp_bd("t3_merged2", 32'h6600_0000);
        tick();

        // Test 4: full static row blocks the first gravity step.
        board_in = 32'h0000_0F66;
        do_reset("t4");
        tick();
        exp_st("t4_fall", 2);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_bd("t4_bd", 32'h0000_0F66);
            exp_st("t4_st", 2);
            tick();
        end
        exp_st("t4_lock", 4);
        exp_lk("t4_lock_pulse", 1);
        exp_bd("t4_lock_bd", 32'h0000_0F66);
        tick();
        exp_st("t4_gen", 0);
        exp_bd("t4_merged", 32'h0000_0F66);
        tick();
        error_in = 1'b1;
        exp_st("t4_spawn", 1);
        exp_bd("t4_merged2", 32'h0000_0F66);
        tick();

        // Test 5: spawn collision -> OVER, frozen until restart.
        exp_st("t5_over", 5);
        exp_go("t5_go", 1);
        exp_bd("t5_frozen0", 32'h0000_0F66);
        tick();
        for (int i = 0; i < 20; i++) begin
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
            btn_drop   = 1'($urandom_range(0, 1));
            error_in   = 1'($urandom_range(0, 1));
            board_in   = $urandom;
            curr_piece = 2'($urandom_range(0, 3));
            exp_st("t5_over_hold", 5);
            exp_go("t5_go_hold", 1);
            exp_lk("t5_lk_hold", 0);
            exp_bd("t5_frozen", 32'h0000_0F66);
            tick();
        end
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_drop   = 1'b0;
        error_in   = 1'b0;
        board_in   = 32'h0000_0066;
        curr_piece = 2'b10;
        do_reset("t5");

        // Test 6: restart in the middle of a hard drop.
        exp_st("t6_spawn", 1);
        tick();
        exp_st("t6_fall", 2);
        tick();
        btn_drop = 1'b1;
        exp_st("t6_drop", 3);
        tick();
        btn_drop = 1'b0;
        exp_bd("t6_drop_bd0", 32'h0000_0066);
        tick();
        exp_bd("t6_drop_bd1", 32'h0000_0660);
        exp_st("t6_drop_st", 3);
        tick();
        do_reset("t6");
        exp_st("t6_after", 1);
        exp_bd("t6_after_bd", 32'h0);
        tick();
        exp_st("t6_refall", 2);
        exp_bd("t6_static_clear", 32'h0);
        tick();
        exp_bd("t6_fresh", 32'h0000_0066);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
